// File: rtl/upsampler.sv
// CIC interpolation sample-rate expander: one buffered input sample becomes CIC_R output samples.
// Optional build macro UPSAMPLER_HOLD_EN selects zero-order hold instead of zero stuffing.
module upsampler #(
  parameter int DATA_WIDTH_INP = 8,
  parameter int CIC_R          = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic [DATA_WIDTH_INP-1:0] inp_samp_data,
  input  logic                      inp_samp_str,
  output logic                      inp_samp_rdy,
  input  logic                      out_tick,
  output logic [DATA_WIDTH_INP-1:0] out_samp_data,
  output logic                      out_samp_str,
  output logic                      underrun
);

  localparam int PHASE_W = (CIC_R > 1) ? $clog2(CIC_R) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(CIC_R - 1);
  localparam logic [PHASE_W-1:0] PHASE_FIRST = (CIC_R > 1) ? PHASE_W'(1) : '0;

  logic [DATA_WIDTH_INP-1:0] pend_q, pend_d;
  logic                      pend_vld_q, pend_vld_d;
  logic [PHASE_W-1:0]        phase_q, phase_d;
  logic [DATA_WIDTH_INP-1:0] out_data_q, out_data_d;
  logic                      out_str_q, out_str_d;
  logic                      underrun_q, underrun_d;
  logic [DATA_WIDTH_INP-1:0] fill;

`ifdef UPSAMPLER_HOLD_EN
  // Output register already holds the last phase-0 sample (or its repeat).
  assign fill = out_data_q;
`else
  assign fill = '0;
`endif

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    phase_d    = phase_q;
    out_data_d = out_data_q;
    out_str_d  = 1'b0;
    underrun_d = 1'b0;

    // Accept and consume are mutually exclusive: accept needs an empty buffer.
    if (inp_samp_str && !pend_vld_q) begin
      pend_d     = inp_samp_data;
      pend_vld_d = 1'b1;
    end

    if (out_tick) begin
      out_str_d = 1'b1;
      if (phase_q == '0) begin
        if (pend_vld_q) begin
          out_data_d = pend_q;
          pend_vld_d = 1'b0;
          phase_d    = PHASE_FIRST;
        end else begin
          out_data_d = fill;
          underrun_d = 1'b1;
        end
      end else begin
        out_data_d = fill;
        phase_d    = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
      end
    end

    if (clear) begin
      pend_d     = '0;
      pend_vld_d = 1'b0;
      phase_d    = '0;
      out_data_d = '0;
      out_str_d  = 1'b0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      phase_q    <= '0;
      out_data_q <= '0;
      out_str_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      phase_q    <= phase_d;
      out_data_q <= out_data_d;
      out_str_q  <= out_str_d;
      underrun_q <= underrun_d;
    end
  end

  assign inp_samp_rdy  = ~pend_vld_q;
  assign out_samp_data = out_data_q;
  assign out_samp_str  = out_str_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_upsampler.sv
// Scoreboard bench for upsampler: CIC_R = 4, 1 and 3 instances driven one after another.
module tb_upsampler;

`ifdef UPSAMPLER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct packed {
    logic       uf;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic       clr4 = 1'b0, str4 = 1'b0, tick4 = 1'b0;
  logic [7:0] din4 = '0;
  logic       rdy4, os4, uf4;
  logic [7:0] dout4;
  logic       clr1 = 1'b0, str1 = 1'b0, tick1 = 1'b0;
  logic [7:0] din1 = '0;
  logic       rdy1, os1, uf1;
  logic [7:0] dout1;
  logic       clr3 = 1'b0, str3 = 1'b0, tick3 = 1'b0;
  logic [7:0] din3 = '0;
  logic       rdy3, os3, uf3;
  logic [7:0] dout3;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q3[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  upsampler #(.DATA_WIDTH_INP(8), .CIC_R(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .clear(clr4),
    .inp_samp_data(din4), .inp_samp_str(str4), .inp_samp_rdy(rdy4),
    .out_tick(tick4), .out_samp_data(dout4), .out_samp_str(os4), .underrun(uf4)
  );

  upsampler #(.DATA_WIDTH_INP(8), .CIC_R(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clr1),
    .inp_samp_data(din1), .inp_samp_str(str1), .inp_samp_rdy(rdy1),
    .out_tick(tick1), .out_samp_data(dout1), .out_samp_str(os1), .underrun(uf1)
  );

  upsampler #(.DATA_WIDTH_INP(8), .CIC_R(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .clear(clr3),
    .inp_samp_data(din3), .inp_samp_str(str3), .inp_samp_rdy(rdy3),
    .out_tick(tick3), .out_samp_data(dout3), .out_samp_str(os3), .underrun(uf3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int which, input logic uf, input logic [7:0] d);
    exp_t e;
    e.uf = uf;
    e.d  = d;
    case (which)
      4:       q4.push_back(e);
      1:       q1.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every strobe pops one expected {underrun, data}; underrun must never pulse without a strobe.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (os4) begin
        if (q4.size() == 0) check("r4_extra_strobe", 32'(1), 32'(0));
        else begin
          e = q4.pop_front();
          check("r4_out", 32'({uf4, dout4}), 32'(e));
        end
      end else if (uf4) check("r4_idle_underrun", 32'(uf4), 32'(0));
      if (os1) begin
        if (q1.size() == 0) check("r1_extra_strobe", 32'(1), 32'(0));
        else begin
          e = q1.pop_front();
          check("r1_out", 32'({uf1, dout1}), 32'(e));
        end
      end else if (uf1) check("r1_idle_underrun", 32'(uf1), 32'(0));
      if (os3) begin
        if (q3.size() == 0) check("r3_extra_strobe", 32'(1), 32'(0));
        else begin
          e = q3.pop_front();
          check("r3_out", 32'({uf3, dout3}), 32'(e));
        end
      end else if (uf3) check("r3_idle_underrun", 32'(uf3), 32'(0));
    end
  end

  initial begin
    logic [7:0] vals [3];
    logic [7:0] f9, f10;
    vals[0] = 8'hFD;
    vals[1] = 8'h07;
    vals[2] = 8'h80;

    // Reset state
    step();
    check("rst_data", 32'(dout4), 32'(0));
    check("rst_str", 32'(os4), 32'(0));
    check("rst_underrun", 32'(uf4), 32'(0));
    check("rst_rdy4", 32'(rdy4), 32'(1));
    check("rst_rdy1", 32'(rdy1), 32'(1));
    check("rst_rdy3", 32'(rdy3), 32'(1));
    reset_n = 1'b1;
    repeat (2) step();

    // Basic burst: accept at cycle 0, ticks cycles 1-4, outputs cycles 2-5
    din4 = 8'h35; str4 = 1'b1;
    push(4, 1'b0, 8'h35);
    repeat (3) push(4, 1'b0, 8'h00);
    step();
    str4 = 1'b0; tick4 = 1'b1;
    check("burst_rdy_c1", 32'(rdy4), 32'(0));
    step();
    check("burst_rdy_c2", 32'(rdy4), 32'(1));
    repeat (3) step();
    tick4 = 1'b0;
    repeat (3) step();
    check("burst_drain", 32'(q4.size()), 32'(0));

    // Streaming: tick every 2 cycles, input every 8 cycles
    for (int c = 0; c < 24; c++) begin
      str4  = (c % 8 == 0);
      din4  = vals[c / 8];
      tick4 = (c % 2 == 1);
      if (str4) begin
        check("stream_rdy", 32'(rdy4), 32'(1));
        push(4, 1'b0, vals[c / 8]);
        repeat (3) push(4, 1'b0, 8'h00);
      end
      step();
    end
    str4 = 1'b0; tick4 = 1'b0;
    repeat (3) step();
    check("stream_drain", 32'(q4.size()), 32'(0));

    // Backpressure: 0x22 held while buffer full, accepted after first phase-0 tick
    din4 = 8'h11; str4 = 1'b1;
    check("bp_rdy_first", 32'(rdy4), 32'(1));
    push(4, 1'b0, 8'h11);
    repeat (3) push(4, 1'b0, 8'h00);
    step();
    din4 = 8'h22;
    check("bp_rdy_full0", 32'(rdy4), 32'(0));
    step();
    check("bp_rdy_full1", 32'(rdy4), 32'(0));
    step();
    tick4 = 1'b1;
    step();
    tick4 = 1'b0;
    check("bp_rdy_after_tick", 32'(rdy4), 32'(1));
    push(4, 1'b0, 8'h22);
    repeat (3) push(4, 1'b0, 8'h00);
    step();
    str4 = 1'b0; tick4 = 1'b1;
    repeat (7) step();
    tick4 = 1'b0;
    repeat (3) step();
    check("bp_drain", 32'(q4.size()), 32'(0));

    // Underrun: three empty ticks, then a sample appears on the very next tick
    tick4 = 1'b1;
    repeat (3) push(4, 1'b1, 8'h00);
    repeat (3) step();
    tick4 = 1'b0; din4 = 8'h05; str4 = 1'b1;
    check("ur_rdy", 32'(rdy4), 32'(1));
    step();
    str4 = 1'b0; tick4 = 1'b1;
    push(4, 1'b0, 8'h05);
    repeat (3) push(4, 1'b0, 8'h00);
    repeat (4) step();
    tick4 = 1'b0;
    repeat (3) step();
    check("ur_drain", 32'(q4.size()), 32'(0));

    // Clear mid-burst
    din4 = 8'h40; str4 = 1'b1;
    step();
    str4 = 1'b0; tick4 = 1'b1;
    push(4, 1'b0, 8'h40);
    step();
    tick4 = 1'b0; clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    check("clr_data", 32'(dout4), 32'(0));
    check("clr_str", 32'(os4), 32'(0));
    check("clr_underrun", 32'(uf4), 32'(0));
    check("clr_rdy", 32'(rdy4), 32'(1));
    din4 = 8'h41; str4 = 1'b1;
    step();
    str4 = 1'b0; tick4 = 1'b1;
    push(4, 1'b0, 8'h41);
    repeat (3) push(4, 1'b0, 8'h00);
    repeat (4) step();
    tick4 = 1'b0;
    repeat (3) step();
    check("clr_drain", 32'(q4.size()), 32'(0));

    // CIC_R = 1 pass-through
    for (int k = 1; k <= 3; k++) begin
      din1 = 8'(k); str1 = 1'b1;
      check("r1_rdy", 32'(rdy1), 32'(1));
      step();
      str1 = 1'b0; tick1 = 1'b1;
      push(1, 1'b0, 8'(k));
      step();
      tick1 = 1'b0;
    end
    repeat (3) step();
    check("r1_drain", 32'(q1.size()), 32'(0));

    // CIC_R = 3: zero stuffing or zero-order hold depending on build
    f9  = HOLD ? 8'd9 : 8'd0;
    f10 = HOLD ? 8'd10 : 8'd0;
    din3 = 8'd9; str3 = 1'b1;
    step();
    str3 = 1'b0; tick3 = 1'b1;
    push(3, 1'b0, 8'd9);
    repeat (2) push(3, 1'b0, f9);
    repeat (3) step();
    tick3 = 1'b0; din3 = 8'd10; str3 = 1'b1;
    step();
    str3 = 1'b0; tick3 = 1'b1;
    push(3, 1'b0, 8'd10);
    repeat (2) push(3, 1'b0, f10);
    push(3, 1'b1, f10);
    repeat (4) step();
    tick3 = 1'b0;
    repeat (3) step();
    check("r3_drain", 32'(q3.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
